// File: rtl/bot_host_if.sv
`default_nettype none
// ============================================================================
// Module   : bot_host_if
// Brief    : System-side Rojobot register endpoint. Snapshots the BOT
//            registers on every upd_sysregs toggle, raises a host interrupt,
//            sequences timed motor commands from a host-loaded FIFO and
//            stops the motors if the BOT stops updating.
// Revision : 1.0 - initial release
// ============================================================================
module bot_host_if #(
    parameter logic [31:0] UPD_TIMEOUT = 32'd50_000_000,
    parameter int          CMD_DEPTH   = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        upd_sysregs,
    input  logic [7:0]  LocX,
    input  logic [7:0]  LocY,
    input  logic [7:0]  BotInfo,
    input  logic [7:0]  Sensors,
    output logic [7:0]  MotCtl,
    input  logic [1:0]  host_addr,
    input  logic        host_wr,
    input  logic        host_rd,
    input  logic [31:0] host_wdata,
    output logic [31:0] host_rdata,
    output logic        irq
);

    localparam int            c_AW    = $clog2(CMD_DEPTH);
    localparam logic [c_AW:0] c_FULL  = (c_AW+1)'(CMD_DEPTH);
    localparam logic [1:0]    c_IDLE  = 2'd0;
    localparam logic [1:0]    c_RUN   = 2'd1;
    localparam logic [1:0]    c_HOLD  = 2'd2;

    logic        r_upd_q;
    logic        r_pending;
    logic        r_ovr;
    logic        r_stall;
    logic        r_cmd_drop;
    logic        r_irq_en;
    logic [15:0] r_upd_count;
    logic [31:0] r_snap;
    logic [31:0] r_wd_cnt;
    logic        r_wd_armed;
    logic [1:0]  r_state;
    logic [15:0] r_rem;
    logic [7:0]  r_mot;
    logic [c_AW:0] r_rd_ptr;
    logic [c_AW:0] r_wr_ptr;
    logic [23:0] r_mem [CMD_DEPTH];

    logic        w_upd_evt;
    logic        w_ctrl_wr;
    logic        w_cmd_wr;
    logic        w_clr_pend;
    logic        w_clr_ovr;
    logic        w_clr_stall;
    logic        w_clr_flush;
    logic        w_clr_drop;
    logic        w_wd_fire;
    logic        w_flush;
    logic [c_AW:0] w_count;
    logic        w_full;
    logic        w_empty;
    logic [23:0] w_head;
    logic        w_pop;
    logic        w_push;
    logic        w_drop_set;
    logic [1:0]  w_nxt_state;
    logic [15:0] w_nxt_rem;
    logic [7:0]  w_nxt_mot;
    logic [31:0] w_status;
    logic        w_unused;

    assign w_upd_evt   = upd_sysregs ^ r_upd_q;
    assign w_ctrl_wr   = host_wr && (host_addr == 2'd2);
    assign w_cmd_wr    = host_wr && (host_addr == 2'd3);
    assign w_clr_pend  = w_ctrl_wr && host_wdata[8];
    assign w_clr_ovr   = w_ctrl_wr && host_wdata[9];
    assign w_clr_stall = w_ctrl_wr && host_wdata[10];
    assign w_clr_flush = w_ctrl_wr && host_wdata[11];
    assign w_clr_drop  = w_ctrl_wr && host_wdata[12];
    assign w_unused    = &{1'b0, host_wdata[31:24]};

    // Watchdog fires exactly once per silence; a fresh update re-arms it.
    assign w_wd_fire = !w_upd_evt && r_wd_armed && (r_wd_cnt == UPD_TIMEOUT - 32'd1);
    assign w_flush   = w_wd_fire || w_clr_flush;

    assign w_count = r_wr_ptr - r_rd_ptr;
    assign w_full  = (w_count == c_FULL);
    assign w_empty = (w_count == '0);
    assign w_head  = r_mem[r_rd_ptr[c_AW-1:0]];

    // Commands are dropped only when the FIFO stays full; flush or stall discard silently.
    assign w_push     = w_cmd_wr && !w_flush && !r_stall && (!w_full || w_pop);
    assign w_drop_set = w_cmd_wr && !w_flush && !r_stall && w_full && !w_pop;

    assign w_status = {r_upd_count, 3'b000, 5'(w_count), r_state, r_cmd_drop,
                       w_empty, w_full, r_stall, r_ovr, r_pending};

    assign MotCtl = r_mot;
    assign irq    = r_pending & r_irq_en;

    // Sequencer next-state: flush dominates, then command pop/expiry.
    always_comb begin
        w_pop       = 1'b0;
        w_nxt_state = r_state;
        w_nxt_rem   = r_rem;
        w_nxt_mot   = r_mot;
        if (w_flush) begin
            w_nxt_state = c_IDLE;
            w_nxt_mot   = 8'h00;
        end else begin
            case (r_state)
                c_IDLE: begin
                    w_nxt_mot = 8'h00;
                    w_pop     = !w_empty;
                end
                c_RUN: begin
                    if (w_upd_evt) begin
                        if (r_rem == 16'd1) begin
                            if (!w_empty) begin
                                w_pop = 1'b1;
                            end else begin
                                w_nxt_state = c_IDLE;
                                w_nxt_mot   = 8'h00;
                            end
                        end else begin
                            w_nxt_rem = r_rem - 16'd1;
                        end
                    end
                end
                c_HOLD: begin
                    w_pop = !w_empty;
                end
                default: begin
                    w_nxt_state = c_IDLE;
                    w_nxt_mot   = 8'h00;
                end
            endcase
            if (w_pop) begin
                w_nxt_mot   = w_head[7:0];
                w_nxt_rem   = w_head[23:8];
                w_nxt_state = (w_head[23:8] == 16'd0) ? c_HOLD : c_RUN;
            end
        end
    end

    // Sequencer state and motor output register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= c_IDLE;
            r_rem   <= 16'd0;
            r_mot   <= 8'h00;
        end else begin
            r_state <= w_nxt_state;
            r_rem   <= w_nxt_rem;
            r_mot   <= w_nxt_mot;
        end
    end

    // FIFO pointers; a flush empties the queue outright.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
        end else if (w_flush) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
        end else begin
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
        end
    end

    // FIFO storage carries no reset; pointers define validity.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr[c_AW-1:0]] <= host_wdata[23:0];
        end
    end

    // Update-event capture: snapshot, counter and sticky status flags.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_upd_q     <= 1'b0;
            r_pending   <= 1'b0;
            r_ovr       <= 1'b0;
            r_upd_count <= 16'd0;
            r_snap      <= 32'd0;
        end else begin
            r_upd_q <= upd_sysregs;
            if (w_upd_evt) begin
                r_pending   <= 1'b1;
                r_upd_count <= r_upd_count + 16'd1;
                r_snap      <= {Sensors, BotInfo, LocY, LocX};
            end else if (w_clr_pend) begin
                r_pending <= 1'b0;
            end
            if (w_upd_evt && r_pending && !w_clr_pend) begin
                r_ovr <= 1'b1;
            end else if (w_clr_ovr) begin
                r_ovr <= 1'b0;
            end
        end
    end

    // Watchdog counter saturates at the limit until the next update.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wd_cnt   <= 32'd0;
            r_wd_armed <= 1'b1;
        end else if (w_upd_evt) begin
            r_wd_cnt   <= 32'd0;
            r_wd_armed <= 1'b1;
        end else if (w_wd_fire) begin
            r_wd_armed <= 1'b0;
        end else if (r_wd_cnt != UPD_TIMEOUT - 32'd1) begin
            r_wd_cnt <= r_wd_cnt + 32'd1;
        end
    end

    // Host-controlled flags; hardware set always beats a host clear.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_stall    <= 1'b0;
            r_cmd_drop <= 1'b0;
            r_irq_en   <= 1'b0;
        end else begin
            if (w_wd_fire) begin
                r_stall <= 1'b1;
            end else if (w_clr_stall) begin
                r_stall <= 1'b0;
            end
            if (w_drop_set) begin
                r_cmd_drop <= 1'b1;
            end else if (w_clr_drop) begin
                r_cmd_drop <= 1'b0;
            end
            if (w_ctrl_wr) begin
                r_irq_en <= host_wdata[0];
            end
        end
    end

    // Registered read port; data holds until the next read strobe.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            host_rdata <= 32'd0;
        end else if (host_rd) begin
            case (host_addr)
                2'd0:    host_rdata <= w_status;
                2'd1:    host_rdata <= r_snap;
                2'd2:    host_rdata <= {31'd0, r_irq_en};
                default: host_rdata <= 32'd0;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_bot_host_if.sv
`default_nettype none
// ============================================================================
// Module   : tb_bot_host_if
// Brief    : Bench for bot_host_if: directed scenarios plus randomized
//            traffic, compared every cycle against a queue-based model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_bot_host_if;

    localparam logic [31:0] c_TO    = 32'd100;
    localparam int          c_DEPTH = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        upd_sysregs = 1'b0;
    logic [7:0]  LocX = 8'h00, LocY = 8'h00, BotInfo = 8'h00, Sensors = 8'h00;
    logic [7:0]  MotCtl;
    logic [1:0]  host_addr = 2'd0;
    logic        host_wr = 1'b0, host_rd = 1'b0;
    logic [31:0] host_wdata = 32'd0;
    logic [31:0] host_rdata;
    logic        irq;

    int vectors = 0;
    int miscompares = 0;
    bit run_cmp = 1'b0;

    bot_host_if #(.UPD_TIMEOUT(c_TO), .CMD_DEPTH(c_DEPTH)) dut (
        .clk(clk), .reset(reset), .upd_sysregs(upd_sysregs),
        .LocX(LocX), .LocY(LocY), .BotInfo(BotInfo), .Sensors(Sensors),
        .MotCtl(MotCtl), .host_addr(host_addr), .host_wr(host_wr),
        .host_rd(host_rd), .host_wdata(host_wdata), .host_rdata(host_rdata),
        .irq(irq)
    );

    always #5 clk = ~clk;

    // Behavioural model: command queue, edge timestamps, sticky flags.
    bit          m_updq, m_pend, m_ovr, m_stall, m_drop, m_irqen;
    longint      m_edge, m_last;
    logic [23:0] m_q[$];
    int          m_mode;
    int          m_rem;
    logic [7:0]  m_mot;
    logic [15:0] m_cnt;
    logic [31:0] m_snap, m_rdata;

    function automatic logic [31:0] m_status();
        return {m_cnt, 3'b000, 5'(m_q.size()), 2'(m_mode), m_drop,
                m_q.size() == 0, m_q.size() == c_DEPTH, m_stall, m_ovr, m_pend};
    endfunction

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_updq = 0; m_pend = 0; m_ovr = 0; m_stall = 0; m_drop = 0; m_irqen = 0;
            m_edge = 0; m_last = 0; m_q.delete(); m_mode = 0; m_rem = 0;
            m_mot = 0; m_cnt = 0; m_snap = 0; m_rdata = 0;
        end else begin
            bit evt, ctrl, cmdw, fire, flush, pop, dset;
            logic [23:0] head;
            m_edge++;
            evt  = (upd_sysregs != m_updq);
            m_updq = upd_sysregs;
            ctrl = host_wr && host_addr == 2'd2;
            cmdw = host_wr && host_addr == 2'd3;
            if (host_rd) begin
                case (host_addr)
                    2'd0: m_rdata = m_status();
                    2'd1: m_rdata = m_snap;
                    2'd2: m_rdata = {31'd0, m_irqen};
                    default: m_rdata = 32'd0;
                endcase
            end
            fire = !evt && (m_edge - m_last == longint'(c_TO));
            if (evt) m_last = m_edge;
            flush = fire || (ctrl && host_wdata[11]);
            pop = 0;
            if (flush) begin
                m_q.delete(); m_mode = 0; m_mot = 0;
            end else begin
                case (m_mode)
                    0: begin m_mot = 0; pop = (m_q.size() > 0); end
                    1: if (evt) begin
                           if (m_rem == 1) begin
                               if (m_q.size() > 0) pop = 1;
                               else begin m_mode = 0; m_mot = 0; end
                           end else m_rem--;
                       end
                    default: pop = (m_q.size() > 0);
                endcase
            end
            if (pop) begin
                head = m_q.pop_front();
                m_mot = head[7:0];
                m_rem = int'(head[23:8]);
                m_mode = (m_rem == 0) ? 2 : 1;
            end
            dset = 0;
            if (cmdw && !flush && !m_stall) begin
                if (m_q.size() < c_DEPTH) m_q.push_back(host_wdata[23:0]);
                else dset = 1;
            end
            m_drop  = dset ? 1'b1 : ((ctrl && host_wdata[12]) ? 1'b0 : m_drop);
            m_ovr   = (evt && m_pend && !(ctrl && host_wdata[8])) ? 1'b1 :
                      ((ctrl && host_wdata[9]) ? 1'b0 : m_ovr);
            m_pend  = evt ? 1'b1 : ((ctrl && host_wdata[8]) ? 1'b0 : m_pend);
            m_stall = fire ? 1'b1 : ((ctrl && host_wdata[10]) ? 1'b0 : m_stall);
            if (ctrl) m_irqen = host_wdata[0];
            if (evt) begin
                m_snap = {Sensors, BotInfo, LocY, LocX};
                m_cnt++;
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Cycle-by-cycle comparison against the model.
    always @(negedge clk) begin
        if (run_cmp && !reset) begin
            chk("MotCtl", {24'd0, MotCtl}, {24'd0, m_mot});
            chk("irq", {31'd0, irq}, {31'd0, m_pend & m_irqen});
            chk("host_rdata", host_rdata, m_rdata);
        end
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        host_wr = 1'b1; host_addr = a; host_wdata = d;
        tick();
        host_wr = 1'b0;
    endtask

    task automatic rd(input logic [1:0] a);
        host_rd = 1'b1; host_addr = a;
        tick();
        host_rd = 1'b0;
    endtask

    task automatic toggle();
        upd_sysregs = ~upd_sysregs;
        tick();
    endtask

    initial begin
        repeat (3) tick();
        reset = 1'b0;
        run_cmp = 1'b1;
        chk("rst_mot", {24'd0, MotCtl}, 32'd0);
        chk("rst_irq", {31'd0, irq}, 32'd0);
        chk("rst_rdata", host_rdata, 32'd0);
        rd(2'd0);
        chk("rst_status", host_rdata, 32'h0000_0010);

        // Snapshot and interrupt
        LocX = 8'h12; LocY = 8'h34; BotInfo = 8'h40; Sensors = 8'h07;
        toggle();
        rd(2'd0); chk("upd_status", host_rdata, 32'h0001_0011);
        rd(2'd1); chk("snap", host_rdata, 32'h0740_3412);
        chk("irq_masked", {31'd0, irq}, 32'd0);
        wr(2'd2, 32'h1);
        chk("irq_on", {31'd0, irq}, 32'd1);

        // Overrun then clear
        LocX = 8'h99;
        toggle();
        rd(2'd0); chk("ovr_status", host_rdata, 32'h0002_0013);
        rd(2'd1); chk("snap2", host_rdata, 32'h0740_3499);
        wr(2'd2, 32'h301);
        chk("irq_clr", {31'd0, irq}, 32'd0);
        rd(2'd0); chk("clr_status", host_rdata, 32'h0002_0010);

        // Update coincident with a pending clear: set wins, no overrun
        host_wr = 1'b1; host_addr = 2'd2; host_wdata = 32'h101;
        upd_sysregs = ~upd_sysregs;
        tick();
        host_wr = 1'b0;
        rd(2'd0); chk("setwins_status", host_rdata, 32'h0003_0011);

        // Timed command followed back-to-back by a hold command
        wr(2'd3, 32'h0000_0355);
        chk("cmd_lat1", {24'd0, MotCtl}, 32'd0);
        wr(2'd3, 32'h0000_00AA);
        chk("cmd_lat2", {24'd0, MotCtl}, 32'h55);
        toggle(); toggle();
        chk("run_mid", {24'd0, MotCtl}, 32'h55);
        toggle();
        chk("b2b", {24'd0, MotCtl}, 32'hAA);
        repeat (5) toggle();
        chk("hold", {24'd0, MotCtl}, 32'hAA);

        // Overfill the FIFO while a command runs with no updates
        wr(2'd2, 32'h801);
        wr(2'd3, 32'h0000_0511);
        tick();
        for (int i = 0; i < 5; i++) wr(2'd3, 32'h0000_0120 + 32'(i));
        rd(2'd0); chk("full_status", host_rdata & 32'h1FF8, 32'h0000_0468);

        // Watchdog stall
        wr(2'd2, 32'h1001);
        repeat (110) tick();
        chk("stall_mot", {24'd0, MotCtl}, 32'd0);
        rd(2'd0); chk("stall_status", host_rdata & 32'h1FFC, 32'h0000_0014);
        wr(2'd3, 32'h0000_0077);
        repeat (3) tick();
        chk("stall_ignore", {24'd0, MotCtl}, 32'd0);
        rd(2'd0); chk("stall_nodrop", host_rdata & 32'h1FFC, 32'h0000_0014);
        wr(2'd2, 32'h401);
        toggle();
        wr(2'd3, 32'h0000_0033);
        tick();
        chk("stall_recover", {24'd0, MotCtl}, 32'h33);

        // Randomized traffic with periodic silent windows
        for (int i = 0; i < 3000; i++) begin
            bit quiet;
            quiet = (i % 600) >= 450;
            if (!quiet && $urandom_range(0, 3) == 0) begin
                upd_sysregs = ~upd_sysregs;
                LocX = 8'($urandom); LocY = 8'($urandom);
                BotInfo = 8'($urandom); Sensors = 8'($urandom);
            end
            host_addr = 2'($urandom_range(0, 3));
            host_wr = ($urandom_range(0, 2) == 0);
            host_rd = ($urandom_range(0, 3) == 0);
            if (host_addr == 2'd2)
                host_wdata = $urandom & (($urandom_range(0, 7) == 0) ? 32'h1F01 : 32'h1701);
            else
                host_wdata = {8'($urandom), 14'd0, 2'($urandom_range(0, 3)), 8'($urandom)};
            tick();
            host_wr = 1'b0; host_rd = 1'b0;
        end

        // Asynchronous reset in the middle of a running command
        wr(2'd2, 32'h1C01);
        toggle();
        wr(2'd3, 32'h0000_0566);
        wr(2'd3, 32'h0000_0077);
        wr(2'd3, 32'h0000_0088);
        tick();
        chk("pre_rst_mot", {24'd0, MotCtl}, 32'h66);
        chk("pre_rst_irq", {31'd0, irq}, 32'd1);
        #2 reset = 1'b1;
        #1;
        chk("async_mot", {24'd0, MotCtl}, 32'd0);
        chk("async_irq", {31'd0, irq}, 32'd0);
        tick();
        reset = 1'b0;
        rd(2'd0); chk("post_rst_status", host_rdata, 32'h0000_0010);
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
